mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2: memory read latency, in cycles from the m_en cycle to the m_rdata-valid cycle; legal range 1..15.
REQ-002 Parameter DATA_BASE, default 16'h0000: 16-bit base added to data-port addresses.
REQ-003 clk  input  1: single clock; all state changes on rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset; clears all state immediately when low.
REQ-005 if_req  input  1: instruction-fetch request; held high until if_ready.
REQ-006 if_addr  input  16: fetch address (pc); stable while if_req is high.
REQ-007 if_ready  output  1: one-cycle fetch-completion pulse.
REQ-008 if_rdata  output  16: fetched instruction; valid when if_ready is high.
REQ-009 d_req  input  1: data request; held high until d_ready.
REQ-010 d_we  input  1: data write enable (1 = store, 0 = load); stable while d_req is high.
REQ-011 d_addr  input  8: data address (aluout); stable while d_req is high.
REQ-012 d_wdata  input  8: store data (writedata); stable while d_req is high.
REQ-013 d_ready  output  1: one-cycle data-completion pulse.
REQ-014 d_rdata  output  16: load data (readdata); valid when d_ready is high.
REQ-015 m_en  output  1: memory access strobe.
REQ-016 m_we  output  1: memory write strobe.
REQ-017 m_addr  output  16: memory address.
REQ-018 m_wdata  output  16: memory write data.
REQ-019 m_rdata  input  16: memory read data.
REQ-020 stall  output  1: processor stall.
REQ-021 conflict_cnt  output  8: saturating count of arbitration conflicts.

Function
REQ-022 FSM states: IDLE, ISSUE, WAIT, RESP; all outputs except stall are registered.
REQ-023 IDLE: if if_req or d_req is sampled high, latch the winner's command and go to ISSUE; otherwise stay in IDLE.
REQ-024 Conflict (if_req and d_req both high in IDLE): grant the port not granted last; last_grant updates on every grant; conflict_cnt increments, saturating at 8'hFF.
REQ-025 ISSUE (exactly 1 cycle): m_en=1; m_we=d_we for a data grant, 0 for a fetch grant; m_addr/m_wdata driven from the latched command; load the wait counter with MEM_LAT; go to WAIT.
REQ-026 Outside ISSUE, m_en=0 and m_we=0; m_addr/m_wdata hold their last values.
REQ-027 WAIT lasts MEM_LAT cycles; in the final WAIT cycle, capture m_rdata into the granted port's rdata register; go to RESP.
REQ-028 RESP (1 cycle): pulse the granted port's ready; go to IDLE.
REQ-029 Data address: m_addr = DATA_BASE + {8'h00, d_addr}, modulo 2^16 (wrap, no error).
REQ-030 Data write: m_wdata = {8'h00, d_wdata}; for a fetch grant m_wdata = 16'h0000.
REQ-031 Write transactions follow the same ISSUE/WAIT/RESP sequence; d_ready pulses in RESP; d_rdata is updated with the captured m_rdata (don't-care contents).
REQ-032 Latency: request sampled at edge N -> m_en in cycle N+1 -> ready in cycle N+2+MEM_LAT; a port's rdata holds until its next capture.
REQ-033 Back-to-back: the earliest next grant is the IDLE cycle after RESP; a still-pending loser is granted then.
REQ-034 Request dropped mid-transaction: the transaction completes and ready still pulses.
REQ-035 stall = (if_req & ~if_ready) | (d_req & ~d_ready), combinational.
REQ-036 if_ready and d_ready are never high in the same cycle.

Reset
REQ-037 reset low: state=IDLE; m_en=0, m_we=0, m_addr=0, m_wdata=0; if_ready=0, d_ready=0; if_rdata=0, d_rdata=0; conflict_cnt=0; wait counter=0; last_grant=fetch (data wins the first conflict).
REQ-038 Assertion mid-transaction aborts immediately: no ready pulse, and m_en drops asynchronously.
REQ-039 After release, the first grant is possible at the first rising edge at which reset is high.

Verification
REQ-040 MEM_LAT=2, fetch-only, if_addr=16'h0010, memory returns 16'h1234 -> m_en in cycle 1, if_ready with if_rdata=16'h1234 in cycle 4, stall high in cycles 0-3.
REQ-041 Both ports request from reset (d_we=0, d_addr=8'h05) -> data granted first with m_addr=16'h0005, fetch granted in the IDLE cycle after d_ready, conflict_cnt=1.
REQ-042 Store d_addr=8'hFF, d_wdata=8'hA5, DATA_BASE=16'hFF80 -> m_en=m_we=1, m_addr=16'h007F (wrap), m_wdata=16'h00A5.
REQ-043 Both ports held permanently high -> grants alternate data, fetch, data, ...; conflict_cnt saturates at 8'hFF and holds.
REQ-044 reset pulsed low during WAIT -> no ready pulse, all outputs at reset values; a fetch issued after release completes normally.
REQ-045 MEM_LAT=1, d_req dropped in the ISSUE cycle -> d_ready still pulses in cycle 3.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data ports share one fixed-latency
// memory, with alternating priority on conflicts and a combinational processor stall.
module mem_arbiter #(
    parameter int          MEM_LAT   = 2,
    parameter logic [15:0] DATA_BASE = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ready,
    output logic [15:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [7:0]  d_addr,
    input  logic [7:0]  d_wdata,
    output logic        d_ready,
    output logic [15:0] d_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata,
    output logic        stall,
    output logic [7:0]  conflict_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt;
    logic        gnt_d;      // 1 = data port holds the current (or most recent) grant
    logic        grant;
    logic        pick_d;
    logic        last_wait;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign grant     = if_req | d_req;
    // On a conflict the port that did not win last time gets the memory.
    assign pick_d    = d_req & (~if_req | ~gnt_d);
    assign last_wait = (wait_cnt == 4'd1);
    assign stall     = (if_req & ~if_ready) | (d_req & ~d_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (last_wait) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_en         <= 1'b0;
            m_we         <= 1'b0;
            m_addr       <= 16'h0000;
            m_wdata      <= 16'h0000;
            if_ready     <= 1'b0;
            d_ready      <= 1'b0;
            if_rdata     <= 16'h0000;
            d_rdata      <= 16'h0000;
            conflict_cnt <= 8'h00;
            wait_cnt     <= 4'd0;
            gnt_d        <= 1'b0;
        end else begin
            m_en     <= 1'b0;
            m_we     <= 1'b0;
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                IDLE: if (grant) begin
                    // Command is latched straight into the memory-side registers.
                    m_en    <= 1'b1;
                    m_we    <= pick_d & d_we;
                    gnt_d   <= pick_d;
                    m_addr  <= pick_d ? DATA_BASE + {8'h00, d_addr} : if_addr;
                    m_wdata <= pick_d ? {8'h00, d_wdata} : 16'h0000;
                    if (if_req && d_req) conflict_cnt <= sat_inc(conflict_cnt);
                end
                ISSUE: wait_cnt <= LAT;
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (last_wait) begin
                        if (gnt_d) begin
                            d_rdata <= m_rdata;
                            d_ready <= 1'b1;
                        end else begin
                            if_rdata <= m_rdata;
                            if_ready <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one default instance scoreboarded against a latency
// memory model, plus a MEM_LAT=1 / DATA_BASE=16'hFF80 instance for wrap and drop cases.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst0, rst1;
    logic        if_req, d_req, d_we;
    logic [15:0] if_addr;
    logic [7:0]  d_addr, d_wdata;

    logic        if_ready0, d_ready0, m_en0, m_we0, stall0;
    logic [15:0] if_rdata0, d_rdata0, m_addr0, m_wdata0, m_rdata0;
    logic [7:0]  cc0;
    logic        if_ready1, d_ready1, m_en1, m_we1, stall1;
    logic [15:0] if_rdata1, d_rdata1, m_addr1, m_wdata1, m_rdata1;
    logic [7:0]  cc1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int c;

    typedef struct {
        bit          is_d;
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    logic [3:0]  mc0 = 4'd0, mc1 = 4'd0;
    logic [15:0] ma0 = 16'h0, ma1 = 16'h0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter u0 (
        .clk(clk), .reset(rst0),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready0), .if_rdata(if_rdata0),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready0), .d_rdata(d_rdata0),
        .m_en(m_en0), .m_we(m_we0), .m_addr(m_addr0), .m_wdata(m_wdata0), .m_rdata(m_rdata0),
        .stall(stall0), .conflict_cnt(cc0)
    );

    mem_arbiter #(.MEM_LAT(1), .DATA_BASE(16'hFF80)) u1 (
        .clk(clk), .reset(rst1),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready1), .if_rdata(if_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready1), .d_rdata(d_rdata1),
        .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_rdata(m_rdata1),
        .stall(stall1), .conflict_cnt(cc1)
    );

    function automatic logic [15:0] memval(input logic [15:0] a);
        return a ^ 16'h1224;
    endfunction

    // Memory returns valid data only in the last cycle of its latency window.
    always @(posedge clk) begin
        if (m_en0) begin mc0 <= 4'd2; ma0 <= m_addr0; end
        else if (mc0 != 4'd0) mc0 <= mc0 - 4'd1;
        if (m_en1) begin mc1 <= 4'd1; ma1 <= m_addr1; end
        else if (mc1 != 4'd0) mc1 <= mc1 - 4'd1;
    end
    assign m_rdata0 = (mc0 == 4'd1) ? memval(ma0) : 16'hDEAD;
    assign m_rdata1 = (mc1 == 4'd1) ? memval(ma1) : 16'hDEAD;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_rdy0(input int lim);
        int n;
        for (n = 0; n < lim; n++) begin
            @(negedge clk);
            if (if_ready0 || d_ready0) break;
        end
        check("rdy_timeout", 32'(n < lim), 1);
    endtask

    task automatic rst_pulse0();
        rst0 = 1'b0;
        #2;
        rst0 = 1'b1;
    endtask

    always @(negedge clk) begin
        if (if_ready0 || d_ready0) begin
            check("both_ready", 32'(if_ready0 & d_ready0), 0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_ready: observed if_ready=%0b d_ready=%0b at cycle %0d expected none",
                       if_ready0, d_ready0, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("ready_port", 32'(d_ready0), 32'(mon_e.is_d));
                check("ready_cycle", cyc, mon_e.cyc);
                check("rdata", 32'(d_ready0 ? d_rdata0 : if_rdata0), 32'(mon_e.data));
            end
        end
    end

    initial begin
        rst0 = 1'b0; rst1 = 1'b0;
        if_req = 1'b0; if_addr = 16'h0; d_req = 1'b0; d_we = 1'b0; d_addr = 8'h0; d_wdata = 8'h0;
        repeat (2) @(negedge clk);
        check("rst_m_en", 32'(m_en0), 0);
        check("rst_m_we", 32'(m_we0), 0);
        check("rst_m_addr", 32'(m_addr0), 0);
        check("rst_m_wdata", 32'(m_wdata0), 0);
        check("rst_if_ready", 32'(if_ready0), 0);
        check("rst_d_ready", 32'(d_ready0), 0);
        check("rst_if_rdata", 32'(if_rdata0), 0);
        check("rst_d_rdata", 32'(d_rdata0), 0);
        check("rst_conflict", 32'(cc0), 0);

        // Fetch-only from reset release
        rst0 = 1'b1; if_req = 1'b1; if_addr = 16'h0010;
        c = cyc;
        sb.push_back('{1'b0, 16'h1234, c + 4});
        #1 check("a_stall_c0", 32'(stall0), 1);
        @(negedge clk);
        check("a_m_en", 32'(m_en0), 1);
        check("a_m_addr", 32'(m_addr0), 'h0010);
        check("a_m_we", 32'(m_we0), 0);
        check("a_m_wdata", 32'(m_wdata0), 0);
        check("a_stall_c1", 32'(stall0), 1);
        @(negedge clk);
        check("a_m_en_wait", 32'(m_en0), 0);
        wait_rdy0(20);
        check("a_stall_rdy", 32'(stall0), 0);
        if_req = 1'b0;

        // Simultaneous requests after reset: data first, then fetch
        @(negedge clk);
        rst_pulse0();
        if_req = 1'b1; if_addr = 16'h0020;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h05;
        c = cyc;
        sb.push_back('{1'b1, memval(16'h0005), c + 4});
        sb.push_back('{1'b0, memval(16'h0020), c + 9});
        @(negedge clk);
        check("b_m_addr_d", 32'(m_addr0), 'h0005);
        wait_rdy0(20);
        d_req = 1'b0;
        wait_rdy0(20);
        if_req = 1'b0;
        check("b_conflict", 32'(cc0), 1);

        // Both held high: alternating grants, saturating conflict count
        @(negedge clk);
        rst_pulse0();
        if_req = 1'b1; if_addr = 16'h0030;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h07;
        c = cyc;
        for (int k = 0; k < 260; k++)
            sb.push_back('{(k % 2) == 0, (k % 2) == 0 ? memval(16'h0007) : memval(16'h0030), c + 4 + 5 * k});
        for (int k = 0; k < 260; k++) begin
            wait_rdy0(20);
            if (k == 9)   check("c_conflict_10", 32'(cc0), 10);
            if (k == 254) check("c_conflict_255", 32'(cc0), 'hFF);
        end
        if_req = 1'b0; d_req = 1'b0;
        check("c_conflict_hold", 32'(cc0), 'hFF);

        // Reset asserted during WAIT aborts the fetch
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0040;
        @(negedge clk);
        check("d_m_en_issue", 32'(m_en0), 1);
        @(negedge clk);
        rst0 = 1'b0;
        #1;
        check("d_m_addr", 32'(m_addr0), 0);
        check("d_if_rdata", 32'(if_rdata0), 0);
        check("d_d_rdata", 32'(d_rdata0), 0);
        check("d_conflict", 32'(cc0), 0);
        check("d_if_ready", 32'(if_ready0), 0);
        if_req = 1'b0;
        repeat (3) @(negedge clk);
        rst0 = 1'b1; if_req = 1'b1; if_addr = 16'h0050;
        sb.push_back('{1'b0, memval(16'h0050), cyc + 4});
        wait_rdy0(20);
        if_req = 1'b0;

        // Reset during ISSUE drops m_en without waiting for a clock
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0060;
        @(negedge clk);
        check("e_m_en_issue", 32'(m_en0), 1);
        rst0 = 1'b0;
        #1 check("e_m_en_async", 32'(m_en0), 0);
        if_req = 1'b0;
        repeat (3) @(negedge clk);

        // Second instance: store with address wrap
        rst1 = 1'b1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'hFF; d_wdata = 8'hA5;
        @(negedge clk);
        check("f_m_en", 32'(m_en1), 1);
        check("f_m_we", 32'(m_we1), 1);
        check("f_m_addr", 32'(m_addr1), 'h007F);
        check("f_m_wdata", 32'(m_wdata1), 'h00A5);
        @(negedge clk);
        check("f_m_we_wait", 32'(m_we1), 0);
        check("f_d_ready_wait", 32'(d_ready1), 0);
        @(negedge clk);
        check("f_d_ready", 32'(d_ready1), 1);
        d_req = 1'b0; d_we = 1'b0;

        // MEM_LAT=1 load with request dropped during ISSUE
        @(negedge clk);
        d_req = 1'b1; d_addr = 8'h10;
        @(negedge clk);
        d_req = 1'b0;
        check("g_m_addr", 32'(m_addr1), 'hFF90);
        check("g_m_we", 32'(m_we1), 0);
        @(negedge clk);
        check("g_d_ready_wait", 32'(d_ready1), 0);
        @(negedge clk);
        check("g_d_ready", 32'(d_ready1), 1);
        check("g_d_rdata", 32'(d_rdata1), 32'(memval(16'hFF90)));
        @(negedge clk);
        check("g_d_ready_pulse", 32'(d_ready1), 0);

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
